// File: rtl/mm_arbiter.sv
// mm_arbiter: arbitrates the external memory-mapped bus between the CPU
// (combinational pass-through, fixed priority) and a single burst DMA
// requester. DMA beats fill idle bus cycles with auto-incrementing addresses.
// Optional starvation guard: define MM_ARB_STARVE_EN to enable cpu_hold.
module mm_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_hold,
  input  logic        dma_start,
  input  logic        dma_we,
  input  logic [15:0] dma_base,
  input  logic [7:0]  dma_len,
  input  logic [15:0] dma_wdata,
  output logic        dma_wr_ack,
  output logic [15:0] dma_rdata,
  output logic        dma_rd_valid,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        bus_re,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("mm_arbiter: STARVE_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        dir_q, dir_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;

  logic        hold;
  logic        cpu_req;
  logic        beat;

  // CPU owns the bus whenever it strobes, unless the starvation guard holds it
  assign cpu_req = (cpu_re | cpu_we) & ~hold;
  assign beat    = (state_q == BURST) & ~cpu_req;

`ifdef MM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;

  assign hold = (state_q == BURST) && (starve_q == STARVE_LIM);

  // Count consecutive BURST cycles lost to the CPU; any DMA beat clears it
  always_comb begin
    starve_d = starve_q;
    if (state_q != BURST || beat) begin
      starve_d = '0;
    end else if (cpu_req) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  // State and burst datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      ptr_q      <= '0;
      rem_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next state: launch on a non-empty start, count beats, one DONE cycle
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dma_start && (dma_len != 8'd0)) begin
          state_d = BURST;
          dir_d   = dma_we;
          ptr_d   = dma_base;
          rem_d   = dma_len;
        end
      end
      BURST: begin
        if (beat) begin
          ptr_d = ptr_q + 16'd1;
          rem_d = rem_q - 8'd1;
          if (!dir_q) begin
            rdata_d    = bus_rdata;
            rd_valid_d = 1'b1;
          end
          if (rem_q == 8'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: bus mux (CPU first, then DMA beat, else idle) and status
  always_comb begin
    bus_re       = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    cpu_rdata    = '0;
    dma_wr_ack   = 1'b0;
    cpu_hold     = hold;
    dma_busy     = (state_q != IDLE);
    dma_done     = (state_q == DONE);
    dma_rdata    = rdata_q;
    dma_rd_valid = rd_valid_q;
    if (cpu_req) begin
      bus_addr  = cpu_addr;
      cpu_rdata = bus_rdata;
      // simultaneous read+write: the write wins, the read is dropped
      if (cpu_we) begin
        bus_we    = 1'b1;
        bus_wdata = cpu_wdata;
      end else begin
        bus_re = 1'b1;
      end
    end else if (beat) begin
      bus_addr   = ptr_q;
      bus_we     = dir_q;
      bus_re     = ~dir_q;
      bus_wdata  = dma_wdata;
      dma_wr_ack = dir_q;
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed testbench for mm_arbiter. Memory model: bus_rdata = bus_addr ^ FFFF.
// Cycle 0 of each burst is the cycle in which dma_start is high.
module tb_mm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_hold;
  logic        dma_start, dma_we;
  logic [15:0] dma_base;
  logic [7:0]  dma_len;
  logic [15:0] dma_wdata, dma_rdata;
  logic        dma_wr_ack, dma_rd_valid, dma_busy, dma_done;
  logic        bus_re, bus_we;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;

  int compared = 0;
  int mismatched = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  assign bus_rdata = bus_addr ^ 16'hFFFF;

  mm_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wr_ack(dma_wr_ack), .dma_rdata(dma_rdata),
    .dma_rd_valid(dma_rd_valid), .dma_busy(dma_busy), .dma_done(dma_done),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle, 2 time units past the rising edge
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_bus_re"}, bus_re, 0);
    chk({tag, "_bus_we"}, bus_we, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_busy"}, dma_busy, 0);
    chk({tag, "_done"}, dma_done, 0);
    chk({tag, "_rd_valid"}, dma_rd_valid, 0);
    chk({tag, "_wr_ack"}, dma_wr_ack, 0);
    chk({tag, "_dma_rdata"}, dma_rdata, 0);
  endtask

  initial begin
    rst = 1'b1; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_start = 0; dma_we = 0; dma_base = '0; dma_len = '0; dma_wdata = '0;
    tick; tick;
    rst = 1'b0; #1;
    chk_quiet("reset");

    // CPU read pass-through while idle
    tick; cpu_re = 1; cpu_addr = 16'h2000; #1;
    chk("cpu_rd_re", bus_re, 1);
    chk("cpu_rd_addr", bus_addr, 16'h2000);
    chk("cpu_rd_data", cpu_rdata, 16'hDFFF);
    // illegal re+we: write goes out, read dropped
    tick; cpu_we = 1; cpu_addr = 16'hA000; cpu_wdata = 16'h1111; #1;
    chk("cpu_both_re", bus_re, 0);
    chk("cpu_both_we", bus_we, 1);
    chk("cpu_both_wdata", bus_wdata, 16'h1111);
    tick; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; #1;
    chk("cpu_off_we", bus_we, 0);

    // Read burst 0x4000 len 3
    tick; dma_start = 1; dma_we = 0; dma_base = 16'h4000; dma_len = 8'd3; #1;
    chk("rb_c0_busy", dma_busy, 0);
    tick; dma_start = 0; #1;
    chk("rb_c1_busy", dma_busy, 1);
    chk("rb_c1_addr", bus_addr, 16'h4000);
    chk("rb_c1_re", bus_re, 1);
    chk("rb_c1_valid", dma_rd_valid, 0);
    tick; #1;
    chk("rb_c2_addr", bus_addr, 16'h4001);
    chk("rb_c2_valid", dma_rd_valid, 1);
    chk("rb_c2_rdata", dma_rdata, 16'hBFFF);
    tick; #1;
    chk("rb_c3_addr", bus_addr, 16'h4002);
    chk("rb_c3_rdata", dma_rdata, 16'hBFFE);
    chk("rb_c3_done", dma_done, 0);
    tick; #1;
    chk("rb_c4_re", bus_re, 0);
    chk("rb_c4_done", dma_done, 1);
    chk("rb_c4_busy", dma_busy, 1);
    chk("rb_c4_valid", dma_rd_valid, 1);
    chk("rb_c4_rdata", dma_rdata, 16'hBFFD);
    tick; #1;
    chk("rb_c5_done", dma_done, 0);
    chk("rb_c5_busy", dma_busy, 0);
    chk("rb_c5_valid", dma_rd_valid, 0);
    chk("rb_c5_rdata_hold", dma_rdata, 16'hBFFD);

    // Write burst 0x6000 len 2 with CPU write collision in cycle 1
    ack_cnt = 0;
    tick; dma_start = 1; dma_we = 1; dma_base = 16'h6000; dma_len = 8'd2; dma_wdata = 16'hA5A5; #1;
    ack_cnt += int'(dma_wr_ack);
    tick; dma_start = 0; cpu_we = 1; cpu_addr = 16'h8000; cpu_wdata = 16'h1234; #1;
    ack_cnt += int'(dma_wr_ack);
    chk("wb_c1_addr", bus_addr, 16'h8000);
    chk("wb_c1_we", bus_we, 1);
    chk("wb_c1_wdata", bus_wdata, 16'h1234);
    chk("wb_c1_ack", dma_wr_ack, 0);
    tick; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; #1;
    ack_cnt += int'(dma_wr_ack);
    chk("wb_c2_addr", bus_addr, 16'h6000);
    chk("wb_c2_we", bus_we, 1);
    chk("wb_c2_wdata", bus_wdata, 16'hA5A5);
    chk("wb_c2_ack", dma_wr_ack, 1);
    tick; dma_wdata = 16'h5A5A; #1;
    ack_cnt += int'(dma_wr_ack);
    chk("wb_c3_addr", bus_addr, 16'h6001);
    chk("wb_c3_wdata", bus_wdata, 16'h5A5A);
    chk("wb_c3_done", dma_done, 0);
    tick; #1;
    ack_cnt += int'(dma_wr_ack);
    chk("wb_c4_done", dma_done, 1);
    chk("wb_c4_we", bus_we, 0);
    chk("wb_ack_count", ack_cnt, 2);
    dma_wdata = '0;

    // Wrap FFFF->0000, start-while-busy ignored
    tick; dma_start = 1; dma_we = 0; dma_base = 16'hFFFF; dma_len = 8'd2; #1;
    tick; dma_start = 0; #1;
    chk("wr_c1_addr", bus_addr, 16'hFFFF);
    tick; dma_start = 1; dma_we = 1; dma_base = 16'h1000; dma_len = 8'd5; #1;
    chk("wr_c2_addr", bus_addr, 16'h0000);
    chk("wr_c2_re", bus_re, 1);
    chk("wr_c2_rdata", dma_rdata, 16'h0000);
    tick; dma_start = 0; #1;
    chk("wr_c3_done", dma_done, 1);
    chk("wr_c3_rdata", dma_rdata, 16'hFFFF);
    chk("wr_c3_bus_we", bus_we, 0);
    tick; #1;
    chk("wr_c4_busy", dma_busy, 0);
    tick; #1;
    chk("wr_c5_busy", dma_busy, 0);
    chk("wr_c5_addr", bus_addr, 0);

    // dma_len = 0 ignored
    tick; dma_start = 1; dma_we = 0; dma_base = 16'h7000; dma_len = 8'd0; #1;
    tick; dma_start = 0; #1;
    chk("len0_c1_busy", dma_busy, 0);
    chk("len0_c1_re", bus_re, 0);
    tick; #1;
    chk("len0_c2_done", dma_done, 0);
    chk("len0_c2_busy", dma_busy, 0);

    // Reset in beat 2 of a len=5 read burst
    tick; dma_start = 1; dma_we = 0; dma_base = 16'h3000; dma_len = 8'd5; #1;
    tick; dma_start = 0; #1;
    chk("rst_c1_addr", bus_addr, 16'h3000);
    tick; rst = 1; #1;
    chk("rst_c2_addr", bus_addr, 16'h3001);
    tick; rst = 0; #1;
    chk_quiet("rst_c3");
    tick; #1;
    chk("rst_c4_done", dma_done, 0);
    chk("rst_c4_busy", dma_busy, 0);

    // CPU reads every cycle during a len=2 burst
    tick; dma_start = 1; dma_we = 0; dma_base = 16'h5000; dma_len = 8'd2; #1;
    for (int i = 1; i <= 10; i++) begin
      tick; dma_start = 0; cpu_re = 1; cpu_addr = 16'h8000 + 16'(i); #1;
      chk("stv_busy", dma_busy, 1);
`ifdef MM_ARB_STARVE_EN
      if (i == 5 || i == 10) begin
        chk("stv_hold", cpu_hold, 1);
        chk("stv_dma_addr", bus_addr, (i == 5) ? 16'h5000 : 16'h5001);
        chk("stv_cpu_rdata_blocked", cpu_rdata, 0);
      end else begin
        chk("stv_hold", cpu_hold, 0);
        chk("stv_cpu_addr", bus_addr, 16'h8000 + 16'(i));
      end
`else
      chk("stv_hold", cpu_hold, 0);
      chk("stv_cpu_addr", bus_addr, 16'h8000 + 16'(i));
      chk("stv_cpu_rdata", cpu_rdata, (16'h8000 + 16'(i)) ^ 16'hFFFF);
`endif
    end
    tick; cpu_re = 0; cpu_addr = '0; #1;
`ifdef MM_ARB_STARVE_EN
    chk("stv_end_done", dma_done, 1);
`else
    chk("stv_end_c11_addr", bus_addr, 16'h5000);
    tick; #1;
    chk("stv_end_c12_addr", bus_addr, 16'h5001);
    tick; #1;
    chk("stv_end_c13_done", dma_done, 1);
`endif
    tick; #1;
    chk("stv_idle_busy", dma_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mm_arbiter.md
# mm_arbiter

Arbiter and burst sequencer for the external memory-mapped bus (addresses with any of bits [15:13] set). It sits between the CPU's external port and the peripheral bus and shares that bus with a single burst DMA requester. CPU accesses pass through combinationally, with zero latency and fixed priority. DMA bursts run one beat per idle bus cycle, with auto-incrementing addresses and a single done pulse.

## Interface
Parameters:
- STARVE_MAX, 8: consecutive blocked DMA cycles before the CPU is held (only used with MM_ARB_STARVE_EN); legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_re  in  1  CPU external read strobe (single cycle, already qualified by the address decode).
- cpu_we  in  1  CPU external write strobe.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  16  CPU store data.
- cpu_rdata  out  16  read data returned to the CPU, same cycle.
- cpu_hold  out  1  request to stall the CPU for this cycle (starvation guard).
- dma_start  in  1  one-cycle pulse that launches a burst.
- dma_we  in  1  burst direction, sampled on dma_start: 1 = write, 0 = read.
- dma_base  in  16  first beat address, sampled on dma_start.
- dma_len  in  8  beat count, sampled on dma_start; 0 = no burst.
- dma_wdata  in  16  write data for the current beat.
- dma_wr_ack  out  1  current write beat was consumed; the source advances to the next word.
- dma_rdata  out  16  registered read data.
- dma_rd_valid  out  1  dma_rdata holds a new beat.
- dma_busy  out  1  burst in progress.
- dma_done  out  1  one-cycle burst completion pulse.
- bus_re, bus_we  out  1  peripheral bus strobes.
- bus_addr, bus_wdata  out  16  peripheral bus address and data.
- bus_rdata  in  16  peripheral read data; combinational and valid in the same cycle.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - dma_start with dma_len≠0 latches dir/addr/len into ptr, remaining = dma_len, and moves to BURST.
  - dma_start with dma_len=0 is ignored: no busy, no done.
- BURST:
  - CPU wins: if cpu_re|cpu_we (and cpu_hold=0), the bus carries the CPU access and the DMA beat is deferred.
  - Otherwise the bus carries a DMA beat: bus_addr=ptr, bus_re=~dir, bus_we=dir, bus_wdata=dma_wdata.
  - Each issued beat: ptr += 1 (16-bit wrap, FFFF→0000) and remaining -= 1.
  - Write beat: dma_wr_ack=1 in the same cycle.
  - Read beat: bus_rdata is registered into dma_rdata, with dma_rd_valid=1 the next cycle.
  - The last beat (remaining==1 when issued) moves the FSM to DONE.
- DONE: dma_done=1 for one cycle, then IDLE.
- dma_start while dma_busy is ignored; latched burst parameters are unaffected.
- cpu_rdata = bus_rdata whenever the CPU owns the bus; otherwise 0.
- Bus idle (no CPU access, no DMA beat): bus_re=bus_we=0, bus_addr/bus_wdata=0.
- cpu_re and cpu_we both high is illegal. Response: the read is dropped and the write goes out.

## Timing
- Reset values:
  - All bus_* outputs 0.
  - cpu_rdata and cpu_hold 0.
  - dma_busy, dma_done, dma_rd_valid and dma_wr_ack 0; dma_rdata 0.
  - FSM in IDLE, counters 0.
- CPU path is purely combinational: 0-cycle latency and no registers in the path.
- dma_busy rises the cycle after dma_start. It stays high through BURST and DONE and falls together with dma_done.
- Minimum burst of N beats with no CPU traffic:
  - Beats occur in cycles 1..N after dma_start.
  - dma_done is in cycle N+1.
  - The last dma_rd_valid is also in cycle N+1, coincident with dma_done.
- Each CPU access during BURST delays the remaining beats by exactly one cycle.
- A rst asserted mid-burst aborts it at the next edge. No dma_done is issued and partial beats already issued are not undone.

## Configuration
- MM_ARB_STARVE_EN defined:
  - An 8-bit counter increments on each BURST cycle in which the CPU took the bus, and clears on any issued DMA beat or outside BURST.
  - When the counter equals STARVE_MAX, cpu_hold=1 for that cycle. The DMA beat is issued, CPU strobes are blocked from the bus, cpu_rdata=0, and the counter clears.
  - The top level stalls the CPU on cpu_hold.
- MM_ARB_STARVE_EN undefined: no counter and cpu_hold is tied 0. The CPU can starve the DMA indefinitely.

## Test plan
- Read burst, no CPU traffic: dma_base=0x4000, len=3, bus_rdata=addr^0xFFFF → bus_addr 4000/4001/4002 in cycles 1-3; dma_rd_valid with BFFF/BFFE/BFFD in cycles 2-4; dma_done in cycle 4.
- Write burst with CPU collision: len=2 to 0x6000, cpu_we at 0x8000 in cycle 1 → cycle 1 bus shows the CPU write; DMA beats in cycles 2-3; exactly two dma_wr_ack pulses; dma_done in cycle 4.
- Wrap and ignore cases: base=0xFFFF, len=2 → addresses FFFF then 0000. dma_start while busy → no effect. dma_len=0 → dma_busy stays 0 and no dma_done.
- Reset mid-burst: rst in beat 2 of a len=5 burst → all outputs 0 next cycle, dma_done never asserts, FSM in IDLE.
- Starvation with MM_ARB_STARVE_EN and STARVE_MAX=4: CPU strobes every cycle during BURST → cpu_hold high on the 5th cycle, when a DMA beat issues. Without the macro, cpu_hold stays 0 and no beat ever issues.
